// File: rtl/fft_sample_fifo_if.sv
// ============================================================================
// fft_sample_fifo_if : peripheral bus + sample stream bundle for fft_sample_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

interface fft_sample_fifo_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        frame_irq;

  modport slave (
    input  per_addr, per_din, per_en, per_we, s_ready,
    output per_dout, s_valid, s_data, frame_irq
  );

  modport master (
    output per_addr, per_din, per_en, per_we, s_ready,
    input  per_dout, s_valid, s_data, frame_irq
  );
endinterface

`default_nettype wire

// File: rtl/fft_sample_fifo.sv
// ============================================================================
// fft_sample_fifo : bus-written 16-entry sample FIFO feeding an FFT core
// Rev 1.0
// ============================================================================
`default_nettype none

module fft_sample_fifo #(
  parameter int          DEPTH      = 16,
  parameter logic [13:0] BASE_WADDR = 14'h90
) (
  input  wire               mclk,
  input  wire               puc_rst_n,
  fft_sample_fifo_if.slave  bus
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          en_q,     en_d;
  logic          irq_q,    irq_d;

  logic sel_data, sel_stat, sel_level;
  logic word_wr, word_rd;
  logic full, empty;
  logic push_req, push, pop, flush, ovf_clr, stat_wr;

  assign sel_data  = bus.per_en && (bus.per_addr == BASE_WADDR);
  assign sel_stat  = bus.per_en && (bus.per_addr == BASE_WADDR + 14'd1);
  assign sel_level = bus.per_en && (bus.per_addr == BASE_WADDR + 14'd2);
  assign word_wr   = (bus.per_we == 2'b11);
  assign word_rd   = (bus.per_we == 2'b00);

  assign full  = (count_q == C_FULL);
  assign empty = (count_q == '0);

  assign push_req = sel_data && word_wr;
  assign push     = push_req && !full;
  assign stat_wr  = sel_stat && word_wr;
  assign flush    = stat_wr && bus.per_din[0];
  assign ovf_clr  = stat_wr && bus.per_din[2];

  assign bus.s_valid   = en_q && !empty;
  assign bus.s_data    = mem_q[rd_ptr_q];
  assign bus.frame_irq = irq_q;
  assign pop           = bus.s_valid && bus.s_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    en_d     = en_q;
    irq_d    = 1'b0;

    if (stat_wr) en_d = bus.per_din[8];

    // A rejected push always sets ovf, even when a clear arrives in the same cycle
    if (push_req && full) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      irq_d = push && !pop && (count_q == C_FULL - 1'b1);
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

  // Sample storage is deliberately left unreset
  always_ff @(posedge mclk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= bus.per_din;
  end

  always_comb begin
    bus.per_dout = 16'h0000;
    if (word_rd) begin
      if (sel_stat)
        bus.per_dout = {7'b0, en_q, 4'b0, full, ovf_q, full, empty};
      else if (sel_level)
        bus.per_dout = {{(15-AW){1'b0}}, count_q};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_sample_fifo.sv
// ============================================================================
// tb_fft_sample_fifo : randomized and directed checks against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fft_sample_fifo;

  localparam logic [13:0] A_DATA  = 14'h90;
  localparam logic [13:0] A_STAT  = 14'h91;
  localparam logic [13:0] A_LEVEL = 14'h92;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [15:0] q[$];
  bit          m_en;
  bit          m_ovf;
  bit          m_irq;

  fft_sample_fifo_if bus();

  fft_sample_fifo #(.DEPTH(16), .BASE_WADDR(14'h90)) dut (
    .mclk      (clk),
    .puc_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_stat();
    bit f;
    f = (q.size() == 16);
    return {7'b0, m_en, 4'b0, f, m_ovf, f, q.size() == 0};
  endfunction

  task automatic idle_bus();
    bus.per_addr = 14'h0;
    bus.per_din  = 16'h0;
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
    bus.s_ready  = 1'b0;
  endtask

  // One clock of stimulus; the model advances using the pre-edge state
  task automatic cycle(input logic [13:0] addr, input logic [15:0] din,
                       input logic en, input logic [1:0] we, input logic rdy);
    bit is_data, is_stat, was_full, pop, flush;
    int old;
    bus.per_addr = addr;
    bus.per_din  = din;
    bus.per_en   = en;
    bus.per_we   = we;
    bus.s_ready  = rdy;
    is_data  = en && we == 2'b11 && addr == A_DATA;
    is_stat  = en && we == 2'b11 && addr == A_STAT;
    was_full = q.size() == 16;
    pop      = m_en && q.size() != 0 && rdy;
    flush    = is_stat && din[0];
    old      = q.size();
    @(posedge clk);
    #1;
    if (is_data && was_full)      m_ovf = 1'b1;
    else if (is_stat && din[2])   m_ovf = 1'b0;
    if (is_stat) m_en = din[8];
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (is_data && !was_full) q.push_back(din);
    end
    m_irq = !flush && old == 15 && q.size() == 16;
    idle_bus();
  endtask

  task automatic bus_read(input logic [13:0] addr, output logic [15:0] d);
    bus.per_addr = addr;
    bus.per_en   = 1'b1;
    bus.per_we   = 2'b00;
    #1;
    d = bus.per_dout;
    bus.per_en   = 1'b0;
    bus.per_addr = 14'h0;
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_en  = 1'b0;
    m_ovf = 1'b0;
    m_irq = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL reset_stat: got %h expected %h", d, 16'h0001); end
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_level: got %h expected %h", d, 16'h0000); end
    n_checks++;
    if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.s_valid); end
    bus_read(A_DATA, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL data_read: got %h expected 0000", d); end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] d;
    cycle(A_STAT, 16'h0100, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(A_DATA, 16'(i), 1'b1, 2'b11, 1'b0);
      n_checks++;
      if (bus.frame_irq !== (i == 15)) begin
        n_fail++; $display("FAIL fill_irq[%0d]: got %b expected %b", i, bus.frame_irq, (i == 15));
      end
    end
    cycle(A_DATA, 16'h0, 1'b0, 2'b00, 1'b0);
    n_checks++;
    if (bus.frame_irq !== 1'b0) begin n_fail++; $display("FAIL irq_hold: got %b expected 0", bus.frame_irq); end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 16'h010A) begin n_fail++; $display("FAIL full_stat: got %h expected 010a", d); end
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'd16) begin n_fail++; $display("FAIL full_level: got %h expected 0010", d); end
    cycle(A_DATA, 16'hBEEF, 1'b1, 2'b11, 1'b0);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 16'h010E) begin n_fail++; $display("FAIL ovf_stat: got %h expected 010e", d); end
    n_checks++;
    if (bus.frame_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq: got %b expected 0", bus.frame_irq); end
  endtask

  task automatic test_drain();
    logic [15:0] d;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bus.s_valid !== 1'b1 || bus.s_data !== 16'(i)) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.s_valid, bus.s_data, 16'(i));
      end
      cycle(A_DATA, 16'h0, 1'b0, 2'b00, 1'b1);
    end
    n_checks++;
    if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", bus.s_valid); end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 16'h0105) begin n_fail++; $display("FAIL drain_stat: got %h expected 0105", d); end
    cycle(A_STAT, 16'h0104, 1'b1, 2'b11, 1'b0);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 16'h0101) begin n_fail++; $display("FAIL ovf_clear: got %h expected 0101", d); end
  endtask

  task automatic test_push_pop_wrap();
    logic [15:0] d;
    logic [15:0] v;
    for (int i = 0; i < 5; i++) cycle(A_DATA, 16'($urandom), 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (bus.s_valid !== 1'b1 || bus.s_data !== q[0]) begin
        n_fail++; $display("FAIL wrap_head[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.s_valid, bus.s_data, q[0]);
      end
      v = 16'($urandom);
      cycle(A_DATA, v, 1'b1, 2'b11, 1'b1);
      bus_read(A_LEVEL, d);
      n_checks++;
      if (d !== 16'd5) begin n_fail++; $display("FAIL wrap_level[%0d]: got %h expected 0005", i, d); end
    end
  endtask

  task automatic test_flush();
    logic [15:0] d;
    cycle(A_STAT, 16'h0101, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) cycle(A_DATA, 16'($urandom), 1'b1, 2'b11, 1'b0);
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'd8) begin n_fail++; $display("FAIL pre_flush_level: got %h expected 0008", d); end
    cycle(A_STAT, 16'h0101, 1'b1, 2'b11, 1'b1);
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'd0) begin n_fail++; $display("FAIL flush_level: got %h expected 0000", d); end
    n_checks++;
    if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.s_valid); end
    cycle(A_DATA, 16'h1234, 1'b1, 2'b01, 1'b0);
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'd0) begin n_fail++; $display("FAIL byte_write: got %h expected 0000", d); end
    // With en cleared, pushes land but stay invisible
    cycle(A_STAT, 16'h0000, 1'b1, 2'b11, 1'b0);
    cycle(A_DATA, 16'h5A5A, 1'b1, 2'b11, 1'b1);
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'd1 || bus.s_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_off: got level=%h v=%b expected level=0001 v=0", d, bus.s_valid);
    end
    cycle(A_STAT, 16'h0100, 1'b1, 2'b11, 1'b0);
    n_checks++;
    if (bus.s_valid !== 1'b1 || bus.s_data !== 16'h5A5A) begin
      n_fail++; $display("FAIL en_on: got v=%b d=%h expected v=1 d=5a5a", bus.s_valid, bus.s_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    int r;
    logic [15:0] sd;
    for (int i = 0; i < 400; i++) begin
      n_checks++;
      if (bus.s_valid !== (m_en && q.size() != 0) ||
          (bus.s_valid === 1'b1 && bus.s_data !== q[0])) begin
        n_fail++; $display("FAIL rand_head[%0d]: got v=%b d=%h expected v=%b d=%h", i, bus.s_valid,
                           bus.s_data, (m_en && q.size() != 0), (q.size() != 0) ? q[0] : 16'h0);
      end
      r = $urandom_range(0, 99);
      if (r < 60) begin
        cycle(A_DATA, 16'($urandom), 1'b1, 2'b11, 1'($urandom_range(0, 2) == 0));
      end else if (r < 66) begin
        sd = 16'h0;
        sd[8] = ($urandom_range(0, 9) != 0);
        sd[2] = ($urandom_range(0, 1) == 0);
        sd[0] = ($urandom_range(0, 4) == 0);
        cycle(A_STAT, sd, 1'b1, 2'b11, 1'($urandom_range(0, 1)));
      end else if (r < 72) begin
        cycle(14'(A_DATA + 14'($urandom_range(0, 2))), 16'($urandom), 1'b1,
              2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
      end else begin
        cycle(A_DATA, 16'($urandom), 1'($urandom_range(0, 1)) & 1'b0, 2'b11, 1'($urandom_range(0, 1)));
      end
      n_checks++;
      if (bus.frame_irq !== m_irq) begin
        n_fail++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, bus.frame_irq, m_irq);
      end
      bus_read(A_STAT, d);
      n_checks++;
      if (d !== exp_stat()) begin n_fail++; $display("FAIL rand_stat[%0d]: got %h expected %h", i, d, exp_stat()); end
      bus_read(A_LEVEL, d);
      n_checks++;
      if (d !== 16'(q.size())) begin n_fail++; $display("FAIL rand_level[%0d]: got %h expected %h", i, d, 16'(q.size())); end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    cycle(A_STAT, 16'h0101, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 10; i++) cycle(A_DATA, 16'($urandom), 1'b1, 2'b11, 1'b0);
    n_checks++;
    if (bus.s_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", bus.s_valid); end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b expected 0", bus.s_valid); end
    n_checks++;
    if (bus.per_dout !== 16'h0) begin n_fail++; $display("FAIL async_dout: got %h expected 0000", bus.per_dout); end
    bus_read(A_LEVEL, d);
    n_checks++;
    if (d !== 16'h0) begin n_fail++; $display("FAIL async_level: got %h expected 0000", d); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(A_DATA, 16'h0, 1'b0, 2'b00, 1'b1);
      n_checks++;
      if (bus.frame_irq !== 1'b0) begin n_fail++; $display("FAIL release_irq[%0d]: got %b expected 0", i, bus.frame_irq); end
    end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL release_stat: got %h expected 0001", d); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_bus();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_push_pop_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
